// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: function codes, FSM state encoding and decode helper.
// The multiplier codes only take effect when ALU_MUL_EN is defined.
package seq_alu_pkg;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result port bundle of seq_alu. Both sides are valid/ready: a beat moves
// on a rising edge where valid && ready; the producer holds its payload until then.
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       func;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, func, A, B, out_ready,
        input  in_ready, out_valid, out_lo, out_hi, zero, ovf
    );

    modport slave (
        input  in_valid, func, A, B, out_ready,
        output in_ready, out_valid, out_lo, out_hi, zero, ovf
    );
endinterface

// File: rtl/seq_alu_mul_iter.sv
// Radix-2 shift-add multiplier over operand magnitudes, WIDTH iterations per product.
// Instantiated by seq_alu only when ALU_MUL_EN is defined.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic               r_busy;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_p;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_next;

    assign w_mag_a = (sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign w_mag_b = (sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_mcand : '0)};
    assign w_next = {w_sum, r_p[WIDTH-1:1]};

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CW'(WIDTH - 1));
    // Sign fix-up rides on the final iteration so no extra cycle is spent.
    assign prod = r_neg ? (~w_next + 1'b1) : w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_p     <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_neg   <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_cnt   <= '0;
            r_mcand <= w_mag_a;
            r_p     <= {{WIDTH{1'b0}}, w_mag_b};
        end else if (r_busy) begin
            r_p   <= w_next;
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus an optional
// iterative multiplier enabled by defining ALU_MUL_EN.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst,
    seq_alu_if.slave bus,
    output state_t o_dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;
    logic             r_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_xfer;
    logic             w_is_mul;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_prod_lo;
    logic             w_prod_zero;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_lo;
    logic             w_ovf;

    assign w_in_ready = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_xfer = (r_state == ST_DONE) && bus.out_ready;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   r_hi;

    assign w_is_mul    = is_mul_op(bus.func);
    assign w_prod_lo   = w_prod[WIDTH-1:0];
    assign w_prod_zero = (w_prod == '0);

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept && w_is_mul),
        .sgn   (bus.func == FN_MULT),
        .A     (bus.A),
        .B     (bus.B),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .prod  (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_hi <= '0;
        end else if (w_mul_done) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
        end
    end

    assign bus.out_hi = r_hi;
`else
    assign w_is_mul    = 1'b0;
    assign w_mul_busy  = 1'b0;
    assign w_mul_done  = 1'b0;
    assign w_prod_lo   = '0;
    assign w_prod_zero = 1'b0;
    assign bus.out_hi  = '0;
`endif

    assign w_sum   = bus.A + bus.B;
    assign w_diff  = bus.A - bus.B;
    assign w_shamt = bus.B[SHW-1:0];

    // Unknown codes (and multiply codes without the multiplier) fall to zero.
    always_comb begin
        w_lo  = '0;
        w_ovf = 1'b0;
        case (bus.func)
            FN_ADD: begin
                w_lo  = w_sum;
                w_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            FN_SUB: begin
                w_lo  = w_diff;
                w_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            FN_AND:  w_lo = bus.A & bus.B;
            FN_OR:   w_lo = bus.A | bus.B;
            FN_XOR:  w_lo = bus.A ^ bus.B;
            FN_NOR:  w_lo = ~(bus.A | bus.B);
            FN_SLT:  w_lo = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            FN_SLTU: w_lo = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            FN_SLL:  w_lo = bus.A << w_shamt;
            FN_SRL:  w_lo = bus.A >> w_shamt;
            FN_SRA:  w_lo = $signed(bus.A) >>> w_shamt;
            default: begin
                w_lo  = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_state_nxt = ST_DONE;
                end else if (!w_mul_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo   <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_lo   <= w_lo;
            r_zero <= (w_lo == '0);
            r_ovf  <= w_ovf;
        end else if (w_mul_done) begin
            r_lo   <= w_prod_lo;
            r_zero <= w_prod_zero;
            r_ovf  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_lo    = r_lo;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu; multiply checks switch on ALU_MUL_EN, otherwise the
// multiply codes are checked as unknown operations.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_fail = 0;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic exp_z, input logic exp_o);
        bus.out_ready = 1'b1;
        bus.func      = f;
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        #1;
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk1({tag, "_valid"}, bus.out_valid, 1'b1);
        chk32({tag, "_lo"}, bus.out_lo, exp_lo);
        chk32({tag, "_hi"}, bus.out_hi, 32'h0);
        chk1({tag, "_zero"}, bus.zero, exp_z);
        chk1({tag, "_ovf"}, bus.ovf, exp_o);
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_test(input string tag, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic exp_z);
        int cycles;
        bus.out_ready = 1'b1;
        bus.func      = f;
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk32({tag, "_state_busy"}, 32'(dbg_state), 32'(ST_BUSY));
        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            chk1({tag, "_busy_in_ready"}, bus.in_ready, 1'b0);
            tick();
            cycles++;
        end
        chk32({tag, "_latency"}, 32'(cycles), 32'd32);
        chk32({tag, "_lo"}, bus.out_lo, exp_lo);
        chk32({tag, "_hi"}, bus.out_hi, exp_hi);
        chk1({tag, "_zero"}, bus.zero, exp_z);
        chk1({tag, "_ovf"}, bus.ovf, 1'b0);
        tick();
    endtask
`endif

    logic [31:0] exp_q[$];

    initial begin
        int          sent;
        int          got;
        logic        was_stalled;
        logic [31:0] held;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.func      = 6'h0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk32("rst_lo", bus.out_lo, 32'h0);
        chk32("rst_hi", bus.out_hi, 32'h0);
        chk1("rst_zero", bus.zero, 1'b0);
        chk1("rst_ovf", bus.ovf, 1'b0);
        chk32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst = 1'b0;
        #1;
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);
        tick();

        // Single-cycle operations
        run_vec("add_ovf",  FN_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        run_vec("sub_zero", FN_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0);
        run_vec("sra_neg",  FN_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0);
        run_vec("sub_ovf",  FN_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_vec("sub_ovf2", FN_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
        run_vec("add_wrap", FN_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        run_vec("and",      FN_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
        run_vec("or",       FN_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0);
        run_vec("xor",      FN_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0);
        run_vec("nor",      FN_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_vec("slt",      FN_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
        run_vec("sltu",     FN_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        run_vec("sll_31",   FN_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1'b0);
        run_vec("srl",      FN_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0);
        run_vec("sra_pos",  FN_SRA,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0);
        run_vec("unknown",  6'h3F,   32'h00000123, 32'h00000456, 32'h00000000, 1'b1, 1'b0);

        // Multiply
`ifdef ALU_MUL_EN
        mul_test("mult_neg",  FN_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        mul_test("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        mul_test("mult_nn",   FN_MULT,  32'hFFFFFFFB, 32'hFFFFFFFB, 32'h00000000, 32'h00000019, 1'b0);
        mul_test("mult_min",  FN_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        mul_test("mult_zero", FN_MULT,  32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b1);
`else
        run_vec("mult_unk",  FN_MULT,  32'hFFFFFFFD, 32'h00000007, 32'h00000000, 1'b1, 1'b0);
        run_vec("multu_unk", FN_MULTU, 32'h00000003, 32'h00000007, 32'h00000000, 1'b1, 1'b0);
`endif

        // Back-to-back ADDs with output stalled in cycles 2-4
        sent        = 0;
        got         = 0;
        was_stalled = 1'b0;
        held        = '0;
        for (int c = 0; c < 12; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (sent < 4);
            bus.func      = FN_ADD;
            bus.A         = 32'(sent + 1);
            bus.B         = 32'(sent + 1);
            #1;
            if (was_stalled) begin
                chk1("b2b_hold_valid", bus.out_valid, 1'b1);
                chk32("b2b_hold_lo", bus.out_lo, held);
            end
            if (bus.out_valid && !bus.out_ready) begin
                chk1("b2b_stall_in_ready", bus.in_ready, 1'b0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("b2b_spurious", 1'b1, 1'b0);
                end else begin
                    chk32("b2b_data", bus.out_lo, exp_q.pop_front());
                end
                got++;
            end
            was_stalled = bus.out_valid && !bus.out_ready;
            held        = bus.out_lo;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(32'(2 * (sent + 1)));
                sent++;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk32("b2b_sent", 32'(sent), 32'd4);
        chk32("b2b_got", 32'(got), 32'd4);
        chk32("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset while a result is held
        bus.out_ready = 1'b0;
        bus.func      = FN_ADD;
        bus.A         = 32'd9;
        bus.B         = 32'd9;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk1("held_valid", bus.out_valid, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk1("rst_done_valid", bus.out_valid, 1'b0);
        chk32("rst_done_lo", bus.out_lo, 32'h0);
        chk32("rst_done_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk1("rst_done_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("rst_done_quiet", bus.out_valid, 1'b0);
        end

`ifdef ALU_MUL_EN
        // Reset in the middle of a multiply
        bus.func     = FN_MULT;
        bus.A        = 32'hFFFFFFFD;
        bus.B        = 32'h00000007;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk1("rst_busy_valid", bus.out_valid, 1'b0);
        chk1("rst_busy_in_ready", bus.in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk1("rst_busy_in_ready_rel", bus.in_ready, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk1("rst_busy_quiet", bus.out_valid, 1'b0);
        end
`endif

        run_vec("post_rst_add", FN_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
